// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared types and constants for the seven-segment scan driver.
//   seg7_t      : segment vector {g,f,e,d,c,b,a}, 1 = segment lit
//   SEG7_TABLE  : hex nibble -> active-high segment pattern (0-9, A, b, C, d, E, F)
//   state_t     : scan controller states (IDLE after reset, SCAN free-running)
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_TABLE [16] = '{
        7'b0111111,   // 0
        7'b0000110,   // 1
        7'b1011011,   // 2
        7'b1001111,   // 3
        7'b1100110,   // 4
        7'b1101101,   // 5
        7'b1111101,   // 6
        7'b0000111,   // 7
        7'b1111111,   // 8
        7'b1100111,   // 9
        7'b1110111,   // A
        7'b1111100,   // b
        7'b0111001,   // C
        7'b1011110,   // d
        7'b1111001,   // E
        7'b1110001    // F
    };

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode -- combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-high segments {g,f,e,d,c,b,a}
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver -- time-multiplexed driver for an N-digit common-anode
// seven-segment display with shadow/display double buffering.
//
// Parameters:
//   NUM_DIGITS  digits scanned (2..16)
//   CLK_DIV     clock cycles each digit stays lit (>= 2)
//   ACTIVE_LOW  1: seg/dp_out/an inverted at the pins (0 = lit/selected)
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   value       packed hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp          decimal point per digit
//   digit_en    per-digit enable (0 = blank)
//   load        capture value/dp/digit_en into the shadow set
//   seg         registered segments {g,f,e,d,c,b,a}
//   dp_out      registered decimal point of the current digit
//   an          registered one-hot anode select
//   frame_done  one-cycle pulse when the scan wraps back to digit 0
//
// Build option: define SEG7_LZB_EN to enable leading-zero blanking.
//
// All outputs are registered from the *next* scan index and the *next*
// display set, so the anode/segment change lands in the same cycle the index
// advances and the freshly reloaded frame is visible on digit 0 together with
// frame_done. Leaving IDLE also reloads the display set, so data loaded before
// that point is shown from the very first slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    state_t                  state, state_n;
    logic [PW-1:0]           presc, presc_n;
    logic [IW-1:0]           idx, idx_n;
    logic                    wrap, reload;

    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_en;

    logic [4*NUM_DIGITS-1:0] dsp_val;
    logic [NUM_DIGITS-1:0]   dsp_dp, dsp_en, dsp_blank;

    // Reload source: a load coinciding with the reload bypasses the shadow.
    logic [4*NUM_DIGITS-1:0] src_val;
    logic [NUM_DIGITS-1:0]   src_dp, src_en, src_blank;

    logic [4*NUM_DIGITS-1:0] dn_val;
    logic [NUM_DIGITS-1:0]   dn_dp, dn_en, dn_blank;

    logic [3:0]              cur_nib;
    seg7_t                   cur_seg;
    logic                    lit;
    logic [6:0]              seg_raw;
    logic                    dp_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    // ---------------- scan controller ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        idx_n   = idx;
        wrap    = 1'b0;
        reload  = 1'b0;
        case (state)
            IDLE: begin
                state_n = SCAN;
                reload  = 1'b1;
            end
            SCAN: begin
                if (presc == PRE_LAST) begin
                    presc_n = '0;
                    if (idx == IDX_LAST) begin
                        idx_n  = '0;
                        wrap   = 1'b1;
                        reload = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- display set next value ----------------
    assign src_val = load ? value    : sh_val;
    assign src_dp  = load ? dp       : sh_dp;
    assign src_en  = load ? digit_en : sh_en;

`ifdef SEG7_LZB_EN
    // Walk down from the top digit; while no enabled non-zero nibble has been
    // seen, zero nibbles without a decimal point are blanked. Digit 0 is
    // outside the walk so it always shows.
    always_comb begin : lzb
        logic lead;
        lead      = 1'b1;
        src_blank = '0;
        for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
            if (src_en[j] && (src_val[4*j +: 4] != 4'h0))
                lead = 1'b0;
            src_blank[j] = lead && (src_val[4*j +: 4] == 4'h0) && !src_dp[j];
        end
    end
`else
    assign src_blank = '0;
`endif

    assign dn_val   = reload ? src_val   : dsp_val;
    assign dn_dp    = reload ? src_dp    : dsp_dp;
    assign dn_en    = reload ? src_en    : dsp_en;
    assign dn_blank = reload ? src_blank : dsp_blank;

    // ---------------- current digit ----------------
    assign cur_nib = dn_val[{idx_n, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    assign lit     = dn_en[idx_n] && !dn_blank[idx_n];
    assign seg_raw = lit ? cur_seg : 7'h00;
    assign dp_raw  = lit && dn_dp[idx_n];
    assign an_raw  = lit ? (NUM_DIGITS'(1) << idx_n) : '0;

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            dsp_val    <= '0;
            dsp_dp     <= '0;
            dsp_en     <= '0;
            dsp_blank  <= '0;
            seg        <= {7{ACTIVE_LOW}};
            dp_out     <= ACTIVE_LOW;
            an         <= {NUM_DIGITS{ACTIVE_LOW}};
            frame_done <= 1'b0;
        end else begin
            presc <= presc_n;
            idx   <= idx_n;
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp;
                sh_en  <= digit_en;
            end
            dsp_val    <= dn_val;
            dsp_dp     <= dn_dp;
            dsp_en     <= dn_en;
            dsp_blank  <= dn_blank;
            seg        <= seg_raw ^ {7{ACTIVE_LOW}};
            dp_out     <= dp_raw ^ ACTIVE_LOW;
            an         <= an_raw ^ {NUM_DIGITS{ACTIVE_LOW}};
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver -- self-checking bench for seg7_scan_driver
// (NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=0). The reference model tracks elapsed
// cycles since reset release and derives slot/frame from plain arithmetic;
// the displayed data is the latest load taken at or before each frame start.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam int FR = ND * CD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (CD),
        .ACTIVE_LOW (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .load       (load),
        .seg        (seg),
        .dp_out     (dp_out),
        .an         (an),
        .frame_done (frame_done)
    );

    // ---------------- reference model state ----------------
    int          m = 0;          // edges since reset released (0 = in reset)
    logic [15:0] lat_val = '0, dsp_val = '0;
    logic [3:0]  lat_dp = '0, lat_en = '0, dsp_dp = '0, dsp_en = '0;
    logic        exp_fd = 1'b0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1100111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    // Leading-zero rule: find the highest enabled non-zero digit, blank zero
    // digits above it that carry no decimal point; digit 0 always shows.
    function automatic bit lzb_blank(input int d);
        bit on = 1'b0;
        int msnz = -1;
`ifdef SEG7_LZB_EN
        on = 1'b1;
`endif
        for (int i = 0; i < ND; i++)
            if (dsp_en[i] && dsp_val[4*i +: 4] != 4'h0) msnz = i;
        return on && d > 0 && d > msnz && dsp_val[4*d +: 4] == 4'h0 && !dsp_dp[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int         s, d;
        @(posedge clk);
        if (rst) begin
            m = 0;
            lat_val = '0; lat_dp = '0; lat_en = '0;
            dsp_val = '0; dsp_dp = '0; dsp_en = '0;
            exp_fd = 1'b0;
        end else begin
            m++;
            s = m - 1;
            if (load) begin
                lat_val = value; lat_dp = dp; lat_en = digit_en;
            end
            if (s % FR == 0) begin
                dsp_val = lat_val; dsp_dp = lat_dp; dsp_en = lat_en;
            end
            exp_fd = (s % FR == 0) && (s > 0);
        end
        ea = '0; es = '0; ed = 1'b0;
        if (m >= 1) begin
            d = ((m - 1) / CD) % ND;
            if (dsp_en[d] && !lzb_blank(d)) begin
                ea = 4'(1 << d);
                es = hex7(dsp_val[4*d +: 4]);
                ed = dsp_dp[d];
            end
        end
        #1;
        chk("an",         32'(an),         32'(ea));
        chk("seg",        32'(seg),        32'(es));
        chk("dp_out",     32'(dp_out),     32'(ed));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp = '0; digit_en = '0;
        repeat (3) step();                      // reset state

        rst = 1'b0;
        load = 1'b1; value = 16'h1234; digit_en = 4'hF; dp = 4'h0;
        step();
        load = 1'b0;
        repeat (5 * FR) step();                 // several frames of 1234

        repeat (5) step();                      // mid-frame load
        load = 1'b1; value = 16'hABCD;
        step();
        load = 1'b0;
        repeat (2 * FR) step();

        for (int g = 0; g < FR && (m % FR) != 0; g++) step();
        load = 1'b1; value = 16'h00F0; dp = 4'b0100; digit_en = 4'hF;
        step();                                 // load in the wrap cycle
        load = 1'b0;
        repeat (FR) step();

        load = 1'b1; value = 16'h5678; dp = 4'h0; digit_en = 4'b0101;
        step();
        load = 1'b0;
        repeat (2 * FR) step();

        for (int i = 0; i < 20; i++) begin      // load held high
            load = 1'b1; value = 16'($urandom); dp = 4'($urandom); digit_en = 4'($urandom);
            step();
        end
        load = 1'b0;
        repeat (FR) step();

        repeat (6) step();                      // reset mid-slot, pending load dropped
        rst = 1'b1; load = 1'b1; value = 16'h9999; digit_en = 4'hF;
        step();
        load = 1'b0;
        step();
        rst = 1'b0;
        repeat (2 * FR) step();

        for (int i = 0; i < 600; i++) begin
            load     = ($urandom_range(0, 9) == 0);
            value    = 16'($urandom);
            dp       = 4'($urandom);
            digit_en = 4'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        repeat (FR) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It latches a packed hex value with per-digit decimal points and an enable mask, then scans one digit at a time at a configurable refresh rate. It drives the shared segment bus and the per-digit anode lines. It sits between the datapath and the board display pins and extends the 0–9 combinational decoder to full hex, multiple digits and tear-free updates.

## Interface
- `NUM_DIGITS`, default 8: number of digits scanned; 2..16.
- `CLK_DIV`, default 100000: clock cycles each digit stays lit; ≥ 2.
- `ACTIVE_LOW`, default 1: when 1, `seg`, `dp_out` and `an` are inverted at the output (0 = lit/selected).
- `clk`, input, 1: sole clock, rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `value`, input, 4*NUM_DIGITS: hex nibbles; nibble i (`value[4i+3:4i]`) goes to digit i; digit 0 is rightmost.
- `dp`, input, NUM_DIGITS: decimal point per digit.
- `digit_en`, input, NUM_DIGITS: 0 blanks that digit (anode never asserted).
- `load`, input, 1: captures `value`/`dp`/`digit_en` into the shadow register.
- `seg`, output, 7: segments `{g,f,e,d,c,b,a}`, registered.
- `dp_out`, output, 1: decimal point of the current digit, registered.
- `an`, output, NUM_DIGITS: one-hot anode select, registered.
- `frame_done`, output, 1: one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Encoding, active-high before polarity: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Two register sets:
  - Shadow: written on `load`.
  - Display: copied from the shadow at frame wrap. Digits therefore never show a mix of old and new values.
- Prescaler counts 0..CLK_DIV-1. At terminal count it issues `tick` and returns to 0.
- Digit index advances on `tick` and wraps NUM_DIGITS-1 → 0.
- On wrap:
  - the display set reloads from the shadow;
  - `frame_done` pulses.
- Scan state machine:
  - `IDLE`: entered on reset; all outputs off. Leaves on the first cycle after reset deasserts and goes to `SCAN`.
  - `SCAN`: free-running; no other states.
- Disabled digit: `an` all inactive, `seg`=0, `dp_out`=0 (before polarity) for its whole slot. The slot time is still consumed.
- Simultaneous `load` and wrap: the new `load` data bypasses the shadow and goes straight into the display set. The shadow is also updated.
- `load` held high: the shadow is rewritten every cycle; the last value before the wrap is shown.

## Timing
- Reset values:
  - prescaler 0, index 0;
  - shadow and display sets 0, `digit_en` all 0;
  - `an` all inactive, `seg`/`dp_out` off (all 1s when ACTIVE_LOW=1);
  - `frame_done` 0.
- Output latency: `an`/`seg`/`dp_out` reflect the new index one cycle after `tick`.
- First lit digit: digit 0, one cycle after leaving `IDLE`, provided it was enabled in a load before the first wrap. Otherwise display data takes effect from the first wrap.
- `frame_done` is asserted in the same cycle the display set reloads. Period = NUM_DIGITS*CLK_DIV cycles.
- `rst` mid-scan: everything returns to reset values on the next edge and any pending load is discarded.

## Configuration
- `SEG7_LZB_EN`, when defined, enables leading-zero blanking. Zero nibbles above the most-significant enabled non-zero nibble are blanked exactly like disabled digits. Digit 0 is never blanked by this rule.
  - A digit whose `dp` is set is never blanked.
  - The blank mask is computed at the display-set reload and registered with it.
- When undefined, every enabled digit shows its nibble, including 0.

## Structure
- Package `seg7_pkg`:
  - `typedef logic [6:0] seg7_t`;
  - 16-entry segment constant table;
  - state enum `{IDLE, SCAN}`.
- Sub-module `seg7_hex_decode`: combinational 4-bit → `seg7_t` using the package table. Instantiated once, on the muxed current nibble.

## Test plan
(NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=0)
- Reset, then `load` `value`=16'h1234, `digit_en`=4'hF, `dp`=0 → after the first wrap, the slots show `an`=0001/`seg`=1100110, 0010/1001111, 0100/1011011, 1000/0000110, each for exactly 4 cycles.
- Scan 5 frames → `frame_done` pulses every 16 cycles, one cycle wide, coincident with digit 0 becoming selected.
- `load` 16'hABCD mid-frame → the current frame keeps 1234; the next frame shows d, C, b, A (1011110, 0111001, 1111100, 1110111).
- `load` asserted in the wrap cycle with 16'h00F0, `dp`=4'b0100 → that frame shows the new data. With `SEG7_LZB_EN`: digit 3 blank; digit 2 shows 0111111 with `dp_out`=1; digit 1 F; digit 0 shown as 0.
- `digit_en`=4'b0101 → slots 1 and 3 give `an`=0000, `seg`=0 for 4 cycles each.
- `rst` asserted mid-slot → next edge: `an`=0000, `seg`=0, `frame_done`=0; after release, the scan restarts at digit 0 with the display set cleared.
